// File: rtl/param_bus_master_pkg.sv
// Shared encodings for the synth-engine parameter bus initiator.
package param_bus_master_pkg;

    localparam int ADR_W_DEF = 7;

    localparam logic BANK_OSC = 1'b1;
    localparam logic BANK_COM = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_RESP    = 3'd5,
        ST_DNEXT   = 3'd6
    } state_t;

endpackage

// File: rtl/param_bus_master.sv
// Parameter bus initiator: sequences single read/write accesses and whole-range
// patch dumps onto the shared adr/data/strobe bus.
module param_bus_master
    import param_bus_master_pkg::*;
#(
    parameter int ADR_W  = ADR_W_DEF,
    parameter int SETTLE = 2
) (
    input  logic             sys_clk,
    input  logic             reset_reg_N,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic             req_sel,
    input  logic [ADR_W-1:0] req_adr,
    input  logic [7:0]       req_wdata,
    input  logic             dump_start,
    input  logic             dump_sel,
    input  logic [ADR_W-1:0] dump_first,
    input  logic [ADR_W-1:0] dump_last,
    output logic             dump_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic [ADR_W-1:0] adr,
    inout  wire  [7:0]       data,
    output logic             write,
    output logic             read,
    output logic             osc_sel,
    output logic             com_sel,
    output logic             sysex_data_patch_send,
    output logic [2:0]       state_dbg
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADR_W-1:0]   cur_q;
    logic [ADR_W-1:0]   last_q;
    logic               is_wr_q;
    logic               is_dump_q;
    logic               sel_q;
    logic [7:0]         wdata_q;
    logic [7:0]         rsp_data_q;
    logic               dump_done_q;
    logic               bus_act;
    logic               drive_en;

    // Handshakes: a transfer happens on a posedge where valid and ready are both
    // high; valid never waits on ready, and rsp_valid/rsp_data hold until taken.
    always_ff @(posedge sys_clk) begin
        if (!reset_reg_N) begin
            state       <= ST_IDLE;
            cnt_q       <= '0;
            cur_q       <= '0;
            last_q      <= '0;
            is_wr_q     <= 1'b0;
            is_dump_q   <= 1'b0;
            sel_q       <= BANK_COM;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            dump_done_q <= 1'b0;
        end else begin
            state       <= state_n;
            dump_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cur_q     <= req_adr;
                        is_wr_q   <= req_rw;
                        sel_q     <= req_sel;
                        wdata_q   <= req_wdata;
                        is_dump_q <= 1'b0;
                    end else if (dump_start) begin
                        cur_q       <= dump_first;
                        last_q      <= dump_last;
                        sel_q       <= dump_sel;
                        is_wr_q     <= 1'b0;
                        is_dump_q   <= 1'b1;
                        dump_done_q <= (dump_first > dump_last);
                    end
                end
                ST_SETUP: cnt_q <= '0;
                ST_STROBE: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Responder latched on the read rising edge and drives until
                    // its grant drops, so the byte is taken on entry to CAPTURE.
                    if (cnt_q == CNT_LAST && !is_wr_q)
                        rsp_data_q <= data;
                end
                ST_DNEXT: begin
                    if (cur_q == last_q)
                        dump_done_q <= 1'b1;
                    else
                        cur_q <= cur_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // All bus outputs decode from the state register so a reset edge drops
    // strobes, selects and data drive together.
    always_comb begin
        state_n               = state;
        req_ready             = 1'b0;
        rsp_valid             = 1'b0;
        bus_act               = 1'b0;
        write                 = 1'b0;
        read                  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_n = ST_SETUP;
                else if (dump_start && !(dump_first > dump_last))
                    state_n = ST_SETUP;
            end
            ST_SETUP: begin
                bus_act = 1'b1;
                state_n = ST_STROBE;
            end
            ST_STROBE: begin
                bus_act = 1'b1;
                write   = is_wr_q;
                read    = !is_wr_q;
                if (cnt_q == CNT_LAST)
                    state_n = is_wr_q ? ST_HOLD : ST_CAPTURE;
            end
            ST_HOLD: begin
                bus_act = 1'b1;
                state_n = ST_IDLE;
            end
            ST_CAPTURE: state_n = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_n = is_dump_q ? ST_DNEXT : ST_IDLE;
            end
            ST_DNEXT: state_n = (cur_q == last_q) ? ST_IDLE : ST_SETUP;
            default: state_n = ST_IDLE;
        endcase
        adr                   = bus_act ? cur_q : '0;
        osc_sel               = bus_act && (sel_q == BANK_OSC);
        com_sel               = bus_act && (sel_q == BANK_COM);
        sysex_data_patch_send = bus_act && !is_wr_q;
        drive_en              = bus_act && is_wr_q;
    end

    assign data      = drive_en ? wdata_q : 8'bz;
    assign rsp_data  = rsp_data_q;
    assign dump_done = dump_done_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_param_bus_master.sv
// Directed bench for param_bus_master with a behavioural two-bank responder.
module tb_param_bus_master;
    import param_bus_master_pkg::*;

    localparam int ADR_W  = 7;
    localparam int SETTLE = 2;

    logic             sys_clk = 1'b0;
    logic             reset_reg_N;
    logic             req_valid, req_rw, req_sel;
    logic             req_ready;
    logic [ADR_W-1:0] req_adr;
    logic [7:0]       req_wdata;
    logic             dump_start, dump_sel;
    logic [ADR_W-1:0] dump_first, dump_last;
    logic             dump_done;
    logic             rsp_valid, rsp_ready;
    logic [7:0]       rsp_data;
    logic [ADR_W-1:0] adr;
    wire  [7:0]       data;
    logic             write, read, osc_sel, com_sel, sysex_data_patch_send;
    logic [2:0]       state_dbg;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // Responder model and bench probe driver
    logic [7:0] mem_osc [0:127];
    logic [7:0] mem_com [0:127];
    logic [7:0] rd_latch;
    int         commit_cnt = 0;
    int         read_cnt = 0;
    logic       tb_drv;
    logic [7:0] tb_val;
    logic       resp_en;
    logic [7:0] resp_val;

    param_bus_master #(.ADR_W(ADR_W), .SETTLE(SETTLE)) dut (
        .sys_clk(sys_clk), .reset_reg_N(reset_reg_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_sel(req_sel), .req_adr(req_adr), .req_wdata(req_wdata),
        .dump_start(dump_start), .dump_sel(dump_sel),
        .dump_first(dump_first), .dump_last(dump_last), .dump_done(dump_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .adr(adr), .data(data), .write(write), .read(read),
        .osc_sel(osc_sel), .com_sel(com_sel),
        .sysex_data_patch_send(sysex_data_patch_send), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    // ---------------- responder ----------------
    always_comb begin
        resp_en  = tb_drv || (sysex_data_patch_send && (osc_sel || com_sel));
        resp_val = tb_drv ? tb_val : rd_latch;
    end
    assign data = resp_en ? resp_val : 8'bz;

    always @(negedge write) begin
        if (osc_sel) begin
            mem_osc[adr] = data;
            commit_cnt++;
        end else if (com_sel) begin
            mem_com[adr] = data;
            commit_cnt++;
        end
    end

    always @(posedge read) begin
        read_cnt++;
        rd_latch = osc_sel ? mem_osc[adr] : mem_com[adr];
    end

    // Bus exclusivity monitor
    always @(negedge sys_clk) begin
        if (reset_reg_N === 1'b1) begin
            checks++;
            if (write && read) begin
                errors++;
                $display("FAIL excl_wr_rd: write=%0b read=%0b required not both", write, read);
            end
            checks++;
            if (write && sysex_data_patch_send) begin
                errors++;
                $display("FAIL excl_drive_grant: write=%0b grant=%0b required not both", write, sysex_data_patch_send);
            end
            checks++;
            if (osc_sel && com_sel) begin
                errors++;
                $display("FAIL excl_sel: osc=%0b com=%0b required not both", osc_sel, com_sel);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic probe_bus(output logic [7:0] v);
        tb_drv = 1'b1;
        tb_val = 8'hC3;
        #1;
        v = data;
        tb_drv = 1'b0;
        #1;
    endtask

    task automatic drive_req(input logic rw, input logic sel, input logic [ADR_W-1:0] a,
                             input logic [7:0] wd);
        req_valid = 1'b1;
        req_rw    = rw;
        req_sel   = sel;
        req_adr   = a;
        req_wdata = wd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic run_dump(input logic sel, input logic [ADR_W-1:0] f, input logic [ADR_W-1:0] l,
                            output int done_cnt, output int done_at, output int busy_bad,
                            output int timeout);
        int post;
        got_q.delete();
        done_cnt = 0;
        done_at  = -1;
        busy_bad = 0;
        timeout  = 1;
        post     = 0;
        dump_sel   = sel;
        dump_first = f;
        dump_last  = l;
        dump_start = 1'b1;
        rsp_ready  = 1'b1;
        step();
        dump_start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done_cnt == 0 && !dump_done && req_ready !== 1'b0) busy_bad++;
            if (rsp_valid && rsp_ready) got_q.push_back(rsp_data);
            if (dump_done) begin
                done_cnt++;
                if (done_at < 0) done_at = got_q.size();
                timeout = 0;
            end
            if (done_cnt > 0) post++;
            if (post > 5) break;
            step();
        end
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] v;
        reset_reg_N = 1'b0;
        repeat (3) step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %0b want 1", req_ready); end
        checks++; if ({write, read, osc_sel, com_sel, sysex_data_patch_send} !== 5'b0) begin
            errors++; $display("FAIL rst_strobes: got %b want 00000", {write, read, osc_sel, com_sel, sysex_data_patch_send}); end
        checks++; if (rsp_valid !== 1'b0 || dump_done !== 1'b0) begin
            errors++; $display("FAIL rst_rsp_done: got %0b%0b want 00", rsp_valid, dump_done); end
        checks++; if (adr !== 7'h00) begin errors++; $display("FAIL rst_adr: got %0h want 0", adr); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", state_dbg, ST_IDLE); end
        probe_bus(v);
        checks++; if (v !== 8'hC3) begin errors++; $display("FAIL rst_data_z: got %0h want c3 (undriven)", v); end
        reset_reg_N = 1'b1;
        step();
    endtask

    task automatic test_write();
        logic [7:0] v;
        int c0;
        c0 = commit_cnt;
        mem_osc[7'h11] = 8'h00;
        drive_req(1'b1, BANK_OSC, 7'h11, 8'h55);
        for (int c = 1; c <= 4; c++) begin
            logic exp_w;
            exp_w = (c == 2 || c == 3);
            checks++; if (write !== exp_w) begin errors++; $display("FAIL wr_strobe_T%0d: got %0b want %0b", c, write, exp_w); end
            checks++; if (osc_sel !== 1'b1 || com_sel !== 1'b0 || adr !== 7'h11) begin
                errors++; $display("FAIL wr_addr_sel_T%0d: osc=%0b com=%0b adr=%0h want 1 0 11", c, osc_sel, com_sel, adr); end
            checks++; if (data !== 8'h55) begin errors++; $display("FAIL wr_data_T%0d: got %0h want 55", c, data); end
            checks++; if (req_ready !== 1'b0 || read !== 1'b0) begin
                errors++; $display("FAIL wr_busy_T%0d: ready=%0b read=%0b want 0 0", c, req_ready, read); end
            if (c == 4) begin
                checks++; if (mem_osc[7'h11] !== 8'h55 || commit_cnt != c0 + 1) begin
                    errors++; $display("FAIL wr_commit: mem=%0h commits=%0d want 55 %0d", mem_osc[7'h11], commit_cnt - c0, 1); end
            end
            step();
        end
        checks++; if (req_ready !== 1'b1 || osc_sel !== 1'b0 || adr !== 7'h00) begin
            errors++; $display("FAIL wr_release: ready=%0b osc=%0b adr=%0h want 1 0 0", req_ready, osc_sel, adr); end
        probe_bus(v);
        checks++; if (v !== 8'hC3) begin errors++; $display("FAIL wr_data_z: got %0h want c3 (undriven)", v); end
    endtask

    task automatic test_read();
        mem_com[7'h00] = 8'h03;
        drive_req(1'b0, BANK_COM, 7'h00, 8'h00);
        for (int c = 1; c <= 5; c++) begin
            logic exp_g, exp_r, exp_v;
            exp_g = (c <= 3);
            exp_r = (c == 2 || c == 3);
            exp_v = (c == 5);
            checks++; if (sysex_data_patch_send !== exp_g || com_sel !== exp_g) begin
                errors++; $display("FAIL rd_grant_T%0d: grant=%0b com=%0b want %0b", c, sysex_data_patch_send, com_sel, exp_g); end
            checks++; if (read !== exp_r || write !== 1'b0) begin
                errors++; $display("FAIL rd_strobe_T%0d: read=%0b write=%0b want %0b 0", c, read, write, exp_r); end
            checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL rd_valid_T%0d: got %0b want %0b", c, rsp_valid, exp_v); end
            if (c < 5) step();
        end
        checks++; if (rsp_data !== 8'h03) begin errors++; $display("FAIL rd_data: got %0h want 03", rsp_data); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h03) begin
                errors++; $display("FAIL rd_hold_%0d: valid=%0b data=%0h want 1 03", k, rsp_valid, rsp_data); end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rd_accept: valid=%0b ready=%0b want 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_dump();
        int dc, da, bb, to, r0, n;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            mem_osc[7'h10 + i] = 8'h40 + 8'(i);
            exp_q.push_back(8'h40 + 8'(i));
        end
        r0 = read_cnt;
        run_dump(BANK_OSC, 7'h10, 7'h19, dc, da, bb, to);
        checks++; if (to != 0) begin errors++; $display("FAIL dump_timeout: no dump_done within budget"); end
        n = got_q.size();
        checks++; if (n != 10) begin errors++; $display("FAIL dump_count: got %0d want 10", n); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL dump_byte: got %0h want %0h", g, e); end
        end
        checks++; if (dc != 1 || da != 10) begin errors++; $display("FAIL dump_done: pulses=%0d after_bytes=%0d want 1 10", dc, da); end
        checks++; if (bb != 0) begin errors++; $display("FAIL dump_ready_low: ready high %0d cycles want 0", bb); end
        checks++; if (read_cnt - r0 != 10) begin errors++; $display("FAIL dump_reads: got %0d want 10", read_cnt - r0); end
    endtask

    task automatic test_dump_edges();
        int dc, da, bb, to, r0;
        r0 = read_cnt;
        dump_sel   = BANK_OSC;
        dump_first = 7'd5;
        dump_last  = 7'd3;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        checks++; if (dump_done !== 1'b1 || req_ready !== 1'b1 || read !== 1'b0) begin
            errors++; $display("FAIL empty_dump: done=%0b ready=%0b read=%0b want 1 1 0", dump_done, req_ready, read); end
        step();
        checks++; if (dump_done !== 1'b0 || read_cnt != r0) begin
            errors++; $display("FAIL empty_dump_after: done=%0b reads=%0d want 0 0", dump_done, read_cnt - r0); end

        mem_com[7'h7E] = 8'hA1;
        mem_com[7'h7F] = 8'hA2;
        r0 = read_cnt;
        run_dump(BANK_COM, 7'h7E, 7'h7F, dc, da, bb, to);
        checks++; if (to != 0 || dc != 1 || da != 2) begin
            errors++; $display("FAIL top_dump_done: timeout=%0d pulses=%0d after=%0d want 0 1 2", to, dc, da); end
        checks++; if (got_q.size() != 2 || read_cnt - r0 != 2) begin
            errors++; $display("FAIL top_dump_count: bytes=%0d reads=%0d want 2 2", got_q.size(), read_cnt - r0); end
        checks++; if (got_q.size() == 2 && (got_q[0] !== 8'hA1 || got_q[1] !== 8'hA2)) begin
            errors++; $display("FAIL top_dump_bytes: got %0h %0h want a1 a2", got_q[0], got_q[1]); end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] v;
        int c0;
        c0 = commit_cnt;
        mem_osc[7'h22] = 8'h00;
        drive_req(1'b1, BANK_OSC, 7'h22, 8'h99);
        step();
        step();
        checks++; if (write !== 1'b1) begin errors++; $display("FAIL rstw_pre: write=%0b want 1", write); end
        reset_reg_N = 1'b0;
        step();
        checks++; if (write !== 1'b0 || osc_sel !== 1'b0 || com_sel !== 1'b0) begin
            errors++; $display("FAIL rstw_drop: write=%0b osc=%0b com=%0b want 0 0 0", write, osc_sel, com_sel); end
        probe_bus(v);
        checks++; if (v !== 8'hC3) begin errors++; $display("FAIL rstw_data_z: got %0h want c3 (undriven)", v); end
        checks++; if (commit_cnt != c0 || mem_osc[7'h22] !== 8'h00) begin
            errors++; $display("FAIL rstw_no_commit: commits=%0d mem=%0h want 0 00", commit_cnt - c0, mem_osc[7'h22]); end
        reset_reg_N = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rstw_ready: ready=%0b valid=%0b want 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_priority();
        int r0, seen_v, seen_d;
        r0 = read_cnt;
        seen_v = 0;
        seen_d = 0;
        mem_com[7'h05] = 8'h00;
        dump_sel   = BANK_COM;
        dump_first = 7'd0;
        dump_last  = 7'd3;
        dump_start = 1'b1;
        drive_req(1'b1, BANK_COM, 7'h05, 8'h77);
        dump_start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid) seen_v++;
            if (dump_done) seen_d++;
            step();
        end
        checks++; if (mem_com[7'h05] !== 8'h77) begin errors++; $display("FAIL prio_write: mem=%0h want 77", mem_com[7'h05]); end
        checks++; if (read_cnt != r0 || seen_v != 0 || seen_d != 0) begin
            errors++; $display("FAIL prio_no_dump: reads=%0d valids=%0d dones=%0d want 0 0 0", read_cnt - r0, seen_v, seen_d); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL prio_idle: ready=%0b want 1", req_ready); end
    endtask

    task automatic test_hold_off();
        int c0, bad, done;
        c0 = commit_cnt;
        bad = 0;
        done = 0;
        mem_com[7'h06] = 8'h00;
        dump_sel   = BANK_OSC;
        dump_first = 7'h10;
        dump_last  = 7'h11;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_sel   = BANK_COM;
        req_adr   = 7'h06;
        req_wdata = 8'h5A;
        for (int c = 0; c < 8; c++) begin
            if (req_ready !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_ready: high %0d cycles want 0", bad); end
        rsp_ready = 1'b1;
        for (int c = 0; c < 100 && done == 0; c++) begin
            if (dump_done) done = 1;
            else step();
        end
        checks++; if (done != 1) begin errors++; $display("FAIL hold_timeout: no dump_done within budget"); end
        checks++; if (commit_cnt != c0 || mem_com[7'h06] !== 8'h00) begin
            errors++; $display("FAIL hold_early: commits=%0d mem=%0h want 0 00", commit_cnt - c0, mem_com[7'h06]); end
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (6) step();
        checks++; if (mem_com[7'h06] !== 8'h5A || commit_cnt != c0 + 1) begin
            errors++; $display("FAIL hold_served: mem=%0h commits=%0d want 5a 1", mem_com[7'h06], commit_cnt - c0); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_osc[i] = 8'h00;
            mem_com[i] = 8'h00;
        end
        rd_latch    = 8'h00;
        tb_drv      = 1'b0;
        tb_val      = 8'h00;
        reset_reg_N = 1'b0;
        req_valid   = 1'b0;
        req_rw      = 1'b0;
        req_sel     = 1'b0;
        req_adr     = '0;
        req_wdata   = '0;
        dump_start  = 1'b0;
        dump_sel    = 1'b0;
        dump_first  = '0;
        dump_last   = '0;
        rsp_ready   = 1'b0;

        test_reset();
        test_write();
        test_read();
        test_dump();
        test_dump_edges();
        test_reset_mid_write();
        test_priority();
        test_hold_off();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: simulation did not finish in budget");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
